// File: rtl/dsq_pkg.sv
// Shared definitions for the dsq_mc squared/absolute-difference PCPI unit:
// FSM state encoding, custom-0 opcode, funct3 mode encodings and the
// per-pair term width helper.
package dsq_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CALC    = 2'd1,
        ST_DONE    = 2'd2,
        ST_RELEASE = 2'd3
    } dsq_state_e;

    localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

    // funct3: bit1 selects square (0) / abs (1), bit0 selects wrap (0) / saturate (1)
    localparam logic [2:0] MODE_SSD_WRAP = 3'b000;
    localparam logic [2:0] MODE_SSD_SAT  = 3'b001;
    localparam logic [2:0] MODE_SAD_WRAP = 3'b010;
    localparam logic [2:0] MODE_SAD_SAT  = 3'b011;

    // Width of one pair's contribution: wide enough for the square of an (ELEM_W+1)-bit difference
    function automatic int unsigned term_width(input int unsigned elem_w);
        return 2 * elem_w + 2;
    endfunction

endpackage

// File: rtl/dsq_term.sv
// One-pair term generator (combinational).
// Ports:
//   a_i, b_i : ELEM_W-bit unsigned elements
//   abs_i    : 1 = absolute difference, 0 = squared difference
//   term_o   : zero-extended term, TERM_W bits
module dsq_term
    import dsq_pkg::*;
#(
    parameter int unsigned ELEM_W = 8,
    parameter int unsigned TERM_W = term_width(ELEM_W)
) (
    input  logic [ELEM_W-1:0] a_i,
    input  logic [ELEM_W-1:0] b_i,
    input  logic              abs_i,
    output logic [TERM_W-1:0] term_o
);

    localparam int unsigned SQ_W = 2 * ELEM_W;

    logic signed [ELEM_W:0] diff;
    logic [ELEM_W-1:0]      mag;
    logic [SQ_W-1:0]        sq;

    // |a-b| always fits in ELEM_W bits, so the square only needs 2*ELEM_W bits
    always_comb begin
        diff   = $signed({1'b0, a_i}) - $signed({1'b0, b_i});
        mag    = diff[ELEM_W] ? ELEM_W'(-diff) : ELEM_W'(diff);
        sq     = SQ_W'(mag) * SQ_W'(mag);
        term_o = abs_i ? TERM_W'(mag) : TERM_W'(sq);
    end

endmodule

// File: rtl/dsq_mc.sv
// Multi-cycle squared/absolute-difference accumulate co-processor on PCPI.
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   rs1         : packed element pairs {a0,b0,a1,b1,...}, MSB first
//   rs2         : accumulator seed
//   instr       : instruction word (custom-0 R-type, funct7 = FUNCT7)
//   valid       : CPU request, held until ready or abort
//   ready, wr   : one-cycle completion / write-back pulse
//   wait_       : combinational busy/claim indication
//   rd          : result, zero whenever ready is low
module dsq_mc
    import dsq_pkg::*;
#(
    parameter int unsigned ELEM_W = 8,
    parameter int unsigned PPC    = 1,
    parameter logic [6:0]  FUNCT7 = 7'b0000101
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] instr,
    input  logic            valid,
    output logic            ready,
    output logic            wait_,
    output logic [XLEN-1:0] rd,
    output logic            wr
);

    localparam int unsigned PAIR_W    = 2 * ELEM_W;
    localparam int unsigned NPAIRS    = XLEN / PAIR_W;
    localparam int unsigned K         = NPAIRS / PPC;
    localparam int unsigned CNT_W     = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned TERM_W    = term_width(ELEM_W);
    localparam int unsigned LANE_STEP = PPC * PAIR_W;
    localparam int unsigned SUM_W     = XLEN + 2;

    dsq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  rs1_q, rs1_d;
    logic [XLEN:0]    acc_q, acc_d;     // bit XLEN is the sticky overflow flag
    logic             sat_q, sat_d;
    logic             abs_q, abs_d;
    logic             ready_q, ready_d;
    logic [XLEN-1:0]  rd_q, rd_d;

    logic [2:0]       funct3;
    logic             match_c;
    logic [XLEN-1:0]  pairs_c;
    logic [ELEM_W-1:0] lane_a [PPC];
    logic [ELEM_W-1:0] lane_b [PPC];
    logic [TERM_W-1:0] term_c [PPC];
    logic [SUM_W-1:0] sum_c;
    logic             carry_c;
    logic [XLEN-1:0]  final_c;

    // Instruction decode
    assign funct3  = instr[14:12];
    assign match_c = (instr[6:0] == OPC_CUSTOM0) && (instr[31:25] == FUNCT7) &&
                     ((funct3 == MODE_SSD_WRAP) || (funct3 == MODE_SSD_SAT) ||
                      (funct3 == MODE_SAD_WRAP) || (funct3 == MODE_SAD_SAT));

    // Lane mux: bring the current group of PPC pairs to the top of the word
    assign pairs_c = rs1_q << (32'(cnt_q) * LANE_STEP);

    for (genvar j = 0; j < PPC; j++) begin : g_lane
        assign lane_a[j] = pairs_c[XLEN-1-j*PAIR_W -: ELEM_W];
        assign lane_b[j] = pairs_c[XLEN-1-j*PAIR_W-ELEM_W -: ELEM_W];

        dsq_term #(
            .ELEM_W (ELEM_W),
            .TERM_W (TERM_W)
        ) u_term (
            .a_i    (lane_a[j]),
            .b_i    (lane_b[j]),
            .abs_i  (abs_q),
            .term_o (term_c[j])
        );
    end

    // Add this cycle's terms onto the running accumulator
    always_comb begin
        sum_c = SUM_W'(acc_q[XLEN-1:0]);
        for (int j = 0; j < PPC; j++) begin
            sum_c = sum_c + SUM_W'(term_c[j]);
        end
        carry_c = |sum_c[SUM_W-1:XLEN];
        final_c = (sat_q && (acc_q[XLEN] || carry_c)) ? '1 : sum_c[XLEN-1:0];
    end

    // Next-state and output logic; ready/rd are loaded on the CALC->DONE transition
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rs1_d   = rs1_q;
        acc_d   = acc_q;
        sat_d   = sat_q;
        abs_d   = abs_q;
        ready_d = 1'b0;
        rd_d    = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (valid && match_c) begin
                    state_d = ST_CALC;
                    rs1_d   = rs1;
                    acc_d   = {1'b0, rs2};
                    sat_d   = funct3[0];
                    abs_d   = funct3[1];
                    cnt_d   = '0;
                end
            end
            ST_CALC: begin
                if (!valid) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = {acc_q[XLEN] | carry_c, sum_c[XLEN-1:0]};
                    if (cnt_q == CNT_W'(K - 1)) begin
                        state_d = ST_DONE;
                        ready_d = 1'b1;
                        rd_d    = final_c;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rs1_q   <= '0;
            acc_q   <= '0;
            sat_q   <= 1'b0;
            abs_q   <= 1'b0;
            ready_q <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rs1_q   <= rs1_d;
            acc_q   <= acc_d;
            sat_q   <= sat_d;
            abs_q   <= abs_d;
            ready_q <= ready_d;
            rd_q    <= rd_d;
        end
    end

    // Claim is combinational; forced low while reset is asserted
    assign wait_ = resetn && (((state_q == ST_IDLE) && valid && match_c) || (state_q == ST_CALC));
    assign ready = ready_q;
    assign wr    = ready_q;
    assign rd    = rd_q;

    // Register-specifier fields and lane bits past the active group are not used
    logic unused_bits;
    assign unused_bits = ^{instr[24:15], instr[11:7], pairs_c};

endmodule

// File: tb/tb_dsq_mc.sv
// Directed self-checking bench for dsq_mc in three configurations:
// default (ELEM_W=8, PPC=1), ELEM_W=4/PPC=2 and ELEM_W=16/PPC=1.
module tb_dsq_mc;
    import dsq_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] rs1, rs2, instr;
    logic [2:0]  valid;
    logic [2:0]  ready, wait_w, wr;
    logic [31:0] rd [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dsq_mc u_dut8 (
        .clk(clk), .resetn(resetn), .rs1(rs1), .rs2(rs2), .instr(instr),
        .valid(valid[0]), .ready(ready[0]), .wait_(wait_w[0]), .rd(rd[0]), .wr(wr[0])
    );

    dsq_mc #(.ELEM_W(4), .PPC(2)) u_dut4 (
        .clk(clk), .resetn(resetn), .rs1(rs1), .rs2(rs2), .instr(instr),
        .valid(valid[1]), .ready(ready[1]), .wait_(wait_w[1]), .rd(rd[1]), .wr(wr[1])
    );

    dsq_mc #(.ELEM_W(16), .PPC(1)) u_dut16 (
        .clk(clk), .resetn(resetn), .rs1(rs1), .rs2(rs2), .instr(instr),
        .valid(valid[2]), .ready(ready[2]), .wait_(wait_w[2]), .rd(rd[2]), .wr(wr[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_instr(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd3, OPC_CUSTOM0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full transaction on unit u; checks claim, latency k+1, result and single pulse
    task automatic issue(input int u, input string tag, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input int k, input logic [31:0] exp);
        int lat;
        lat = 0;
        rs1 = a; rs2 = b; instr = mk_instr(7'b0000101, f3);
        valid[u] = 1'b1;
        #1;
        check({tag, ".wait_T"}, 32'(wait_w[u]), 32'd1);
        step();
        // operands only need to be stable in the accept cycle
        rs1 = 32'hDEADBEEF; rs2 = 32'h13579BDF; instr = 32'h0;
        for (int c = 1; c <= 12; c++) begin
            if (ready[u]) begin
                lat = c;
                break;
            end
            check({tag, ".wait_busy"}, 32'(wait_w[u]), 32'd1);
            check({tag, ".rd_idle"}, rd[u], 32'd0);
            step();
        end
        check({tag, ".latency"}, 32'(lat), 32'(k + 1));
        check({tag, ".rd"}, rd[u], exp);
        check({tag, ".wr"}, 32'(wr[u]), 32'd1);
        check({tag, ".wait_rdy"}, 32'(wait_w[u]), 32'd0);
        step();
        check({tag, ".single_pulse"}, 32'(ready[u]), 32'd0);
        check({tag, ".rd_after"}, rd[u], 32'd0);
        valid[u] = 1'b0;
        step();
        step();
    endtask

    // Hold a non-matching request for 20 cycles on the default unit
    task automatic reject(input string tag, input logic [6:0] f7, input logic [2:0] f3);
        logic any_w, any_r;
        any_w = 1'b0; any_r = 1'b0;
        rs1 = 32'h0A030507; rs2 = 32'd100; instr = mk_instr(f7, f3);
        valid[0] = 1'b1;
        repeat (20) begin
            #1;
            any_w = any_w | wait_w[0];
            any_r = any_r | ready[0] | wr[0];
            step();
        end
        check({tag, ".wait"}, 32'(any_w), 32'd0);
        check({tag, ".ready_wr"}, 32'(any_r), 32'd0);
        valid[0] = 1'b0;
        step();
    endtask

    initial begin
        logic seen;
        resetn = 1'b0; valid = '0; rs1 = '0; rs2 = '0; instr = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.ready", 32'(ready[0]), 32'd0);
        check("reset.wr", 32'(wr[0]), 32'd0);
        check("reset.wait", 32'(wait_w[0]), 32'd0);
        check("reset.rd", rd[0], 32'd0);
        resetn = 1'b1;
        step();

        // Default configuration: K=2
        issue(0, "ssd_wrap", 3'b000, 32'h0A030507, 32'd100, 2, 32'd153);
        issue(0, "ssd_sat", 3'b001, 32'hFF00FF00, 32'hFFFF0000, 2, 32'hFFFFFFFF);
        issue(0, "ssd_wrap_ovf", 3'b000, 32'hFF00FF00, 32'hFFFF0000, 2, 32'h0000FC02);
        issue(0, "sad_wrap", 3'b010, 32'h0A030507, 32'd0, 2, 32'd9);
        issue(0, "sad_sat_noovf", 3'b011, 32'h0A030507, 32'd5, 2, 32'd14);

        // ELEM_W=4, PPC=2: K=2
        issue(1, "w4_sad", 3'b010, 32'h31201302, 32'd0, 2, 32'd8);
        issue(1, "w4_ssd", 3'b000, 32'h31201302, 32'd0, 2, 32'd16);

        // ELEM_W=16, PPC=1: K=1
        issue(2, "w16_ssd", 3'b000, 32'h0010000D, 32'd1, 1, 32'd10);
        issue(2, "w16_sad", 3'b010, 32'h0010000D, 32'd1, 1, 32'd4);
        issue(2, "w16_sat", 3'b001, 32'hFFFF0000, 32'hFFFFFFFF, 1, 32'hFFFFFFFF);
        issue(2, "w16_wrap", 3'b000, 32'hFFFF0000, 32'hFFFFFFFF, 1, 32'hFFFE0000);

        // Decode rejects
        reject("rej_f7", 7'b0000110, 3'b000);
        reject("rej_f3", 7'b0000101, 3'b100);

        // Abort at T+1, then reissue
        rs1 = 32'h0A030507; rs2 = 32'd100; instr = mk_instr(7'b0000101, 3'b000);
        valid[0] = 1'b1;
        step();
        valid[0] = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            step();
            seen = seen | ready[0] | wr[0];
        end
        check("abort.no_ready", 32'(seen), 32'd0);
        check("abort.idle", 32'(wait_w[0]), 32'd0);
        issue(0, "reissue", 3'b000, 32'h0A030507, 32'd100, 2, 32'd153);

        // Asynchronous reset while in CALC
        rs1 = 32'hFF00FF00; rs2 = 32'hFFFF0000; instr = mk_instr(7'b0000101, 3'b001);
        valid[0] = 1'b1;
        step();
        check("rst_calc.busy", 32'(wait_w[0]), 32'd1);
        resetn = 1'b0;
        #1;
        check("rst_calc.ready", 32'(ready[0]), 32'd0);
        check("rst_calc.wr", 32'(wr[0]), 32'd0);
        check("rst_calc.wait", 32'(wait_w[0]), 32'd0);
        check("rst_calc.rd", rd[0], 32'd0);
        valid[0] = 1'b0;
        #1;
        resetn = 1'b1;
        #1;
        check("rst_calc.idle_now", 32'(wait_w[0]), 32'd0);
        step();
        issue(0, "after_reset", 3'b000, 32'h0A030507, 32'd100, 2, 32'd153);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
